// File: rtl/bcd_disp_pkg.sv
// Shared 7-segment constants for the display blocks.
// Patterns are active-low, segments g..a on bits 6..0.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] AN_UNITS  = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;
  localparam logic [1:0] AN_OFF    = 2'b11;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10-15 are not valid BCD and show a single dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan_2digit.sv
// Two-digit multiplexed 7-segment driver with per-frame snapshot of the
// BCD inputs, optional leading-zero blanking and per-digit decimal points.
module bcd_display_scan_2digit
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] q0,
  input  logic [3:0] q1,
  input  logic       blank_lz,
  input  logic [1:0] dp_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic [3:0]       snap0_q, snap0_d;
  logic [3:0]       snap1_q, snap1_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             dp_q, dp_d;

  logic             tick;
  logic [3:0]       digit;
  logic [6:0]       digit_seg;

  assign tick  = (cnt_q == CNT_LAST);
  assign digit = sel_q ? snap1_q : snap0_q;

  bcd_to_7seg u_dec (
    .code (digit),
    .seg  (digit_seg)
  );

  // Both digits are captured together at the end of the tens slot so a
  // frame never mixes values from different cycles.
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    sel_d   = tick ? ~sel_q : sel_q;
    snap0_d = snap0_q;
    snap1_d = snap1_q;
    if (tick && sel_q) begin
      snap0_d = q0;
      snap1_d = q1;
    end
  end

  always_comb begin
    seg_d = digit_seg;
    an_d  = AN_UNITS;
    dp_d  = ~dp_in[0];
    if (sel_q) begin
      if (blank_lz && (snap1_q == 4'd0)) begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        dp_d  = 1'b1;
      end else begin
        an_d  = AN_TENS;
        dp_d  = ~dp_in[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      snap0_q <= 4'd0;
      snap1_q <= 4'd0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_display_scan_2digit.sv
// Directed bench for bcd_display_scan_2digit with SCAN_DIV = 4.
// Each slot run states the digit, dp level and blanking it must show.
module tb_bcd_display_scan_2digit;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst;
  logic [3:0] q0;
  logic [3:0] q1;
  logic       blank_lz;
  logic [1:0] dp_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;

  bcd_display_scan_2digit #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .q0       (q0),
    .q1       (q1),
    .blank_lz (blank_lz),
    .dp_in    (dp_in),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of reset, outputs must be blank on that edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    check({tag, "_rst_an"},  {6'd0, an},  8'h03);
    check({tag, "_rst_seg"}, {1'b0, seg}, 8'h7F);
    check({tag, "_rst_dp"},  {7'd0, dp},  8'h01);
    rst = 1'b0;
  endtask

  // n edges of one slot: slot 0 = units, 1 = tens.
  task automatic run_slot(input string tag, input int slot, input int d,
                          input logic exp_dp, input logic blanked, input int n);
    logic [1:0] ea;
    logic [6:0] es;
    ea = (slot == 0) ? 2'b10 : (blanked ? 2'b11 : 2'b01);
    es = blanked ? 7'h7F : exp_seg(d);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_an"},  {6'd0, an},  {6'd0, ea});
      check({tag, "_seg"}, {1'b0, seg}, {1'b0, es});
      check({tag, "_dp"},  {7'd0, dp},  {7'd0, exp_dp});
    end
  endtask

  initial begin
    rst      = 1'b1;
    q0       = 4'd0;
    q1       = 4'd0;
    blank_lz = 1'b0;
    dp_in    = 2'b00;
    step();
    step();

    // basic alternation, first frame shows the reset snapshot
    q0 = 4'd7;
    q1 = 4'd3;
    do_reset("a");
    run_slot("a_u0", 0, 0, 1'b1, 1'b0, 4);
    run_slot("a_t0", 1, 0, 1'b1, 1'b0, 4);
    run_slot("a_u7", 0, 7, 1'b1, 1'b0, 4);
    run_slot("a_t3", 1, 3, 1'b1, 1'b0, 4);
    run_slot("a_u7b", 0, 7, 1'b1, 1'b0, 4);
    run_slot("a_t3b", 1, 3, 1'b1, 1'b0, 4);

    // mid-frame change is deferred to the next frame
    q0 = 4'd5;
    q1 = 4'd3;
    do_reset("b");
    run_slot("b_u0", 0, 0, 1'b1, 1'b0, 4);
    run_slot("b_t0", 1, 0, 1'b1, 1'b0, 4);
    run_slot("b_u5a", 0, 5, 1'b1, 1'b0, 2);
    q0 = 4'd6;
    run_slot("b_u5b", 0, 5, 1'b1, 1'b0, 2);
    run_slot("b_t3", 1, 3, 1'b1, 1'b0, 4);
    run_slot("b_u6", 0, 6, 1'b1, 1'b0, 4);

    // leading-zero blanking on and off
    q0       = 4'd4;
    q1       = 4'd0;
    blank_lz = 1'b1;
    do_reset("c");
    run_slot("c_u0", 0, 0, 1'b1, 1'b0, 4);
    run_slot("c_tb0", 1, 0, 1'b1, 1'b1, 4);
    run_slot("c_u4", 0, 4, 1'b1, 1'b0, 4);
    run_slot("c_tb", 1, 0, 1'b1, 1'b1, 4);
    blank_lz = 1'b0;
    run_slot("c_u4b", 0, 4, 1'b1, 1'b0, 4);
    run_slot("c_t0", 1, 0, 1'b1, 1'b0, 4);

    // invalid code dash and decimal points
    q0    = 4'hC;
    q1    = 4'd1;
    dp_in = 2'b01;
    do_reset("d");
    run_slot("d_u0", 0, 0, 1'b0, 1'b0, 4);
    run_slot("d_t0", 1, 0, 1'b1, 1'b0, 4);
    run_slot("d_uc", 0, 12, 1'b0, 1'b0, 4);
    run_slot("d_t1", 1, 1, 1'b1, 1'b0, 4);
    run_slot("e_uc", 0, 12, 1'b0, 1'b0, 4);
    run_slot("e_t1", 1, 1, 1'b1, 1'b0, 2);

    // reset mid tens slot abandons the frame
    do_reset("e");
    run_slot("e_u0", 0, 0, 1'b0, 1'b0, 4);
    run_slot("e_t0", 1, 0, 1'b1, 1'b0, 4);
    run_slot("e_ucc", 0, 12, 1'b0, 1'b0, 4);
    run_slot("e_t1b", 1, 1, 1'b1, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
